// File: rtl/fifo_rd_drain_pkg.sv
// Shared types and constants for the FIFO read-side drain engine.
package fifo_rd_pkg;

   localparam int RD_BUF_DEPTH = 2;
   localparam int RD_LATENCY   = 1;

   typedef enum logic [1:0] {
      OCC_EMPTY = 2'd0,
      OCC_ONE   = 2'd1,
      OCC_TWO   = 2'd2
   } occ_t;

   // Words held or owed to the buffer once this cycle's pop retires.
   // A pop implies occ >= 1, so the result never goes negative.
   function automatic logic [2:0] credit_sum(input occ_t occ, input logic inflight,
                                             input logic pop);
      return {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
   endfunction

endpackage

// File: rtl/fifo_rd_drain_if.sv
// FIFO read port plus downstream valid/ready stream seen by the drain engine.
interface fifo_rd_drain_if #(
   parameter int DATA_WIDTH = 8
);

   logic                  fifo_empty;
   logic                  fifo_rd_en;
   logic [DATA_WIDTH-1:0] fifo_rdata;
   logic                  m_valid;
   logic                  m_ready;
   logic [DATA_WIDTH-1:0] m_data;

   modport master (
      input  fifo_empty, fifo_rdata, m_ready,
      output fifo_rd_en, m_valid, m_data
   );

   modport slave (
      output fifo_empty, fifo_rdata, m_ready,
      input  fifo_rd_en, m_valid, m_data
   );

endinterface

// File: rtl/fifo_rd_drain_skid_buf.sv
// Two-entry ordered buffer (head/tail) with push, pop and occupancy state.
module rd_skid_buf
   import fifo_rd_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  push,
   input  logic                  pop,
   input  logic [DATA_WIDTH-1:0] din,
   output occ_t                  occ,
   output logic [DATA_WIDTH-1:0] head
);

   occ_t                  occ_nxt;
   logic [DATA_WIDTH-1:0] head_nxt;
   logic [DATA_WIDTH-1:0] tail;
   logic [DATA_WIDTH-1:0] tail_nxt;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         occ  <= OCC_EMPTY;
         head <= '0;
         tail <= '0;
      end else begin
         occ  <= occ_nxt;
         head <= head_nxt;
         tail <= tail_nxt;
      end
   end

   always_comb begin
      occ_nxt  = occ;
      head_nxt = head;
      tail_nxt = tail;
      case ({push, pop})
         2'b10: begin
            case (occ)
               OCC_EMPTY: begin
                  head_nxt = din;
                  occ_nxt  = OCC_ONE;
               end
               OCC_ONE: begin
                  tail_nxt = din;
                  occ_nxt  = OCC_TWO;
               end
               // Push into a full buffer is unreachable; hold contents.
               default: ;
            endcase
         end
         2'b01: begin
            case (occ)
               OCC_ONE: occ_nxt = OCC_EMPTY;
               OCC_TWO: begin
                  head_nxt = tail;
                  occ_nxt  = OCC_ONE;
               end
               default: ;
            endcase
         end
         2'b11: begin
            // New word lands behind whatever survives the pop.
            case (occ)
               OCC_ONE: head_nxt = din;
               OCC_TWO: begin
                  head_nxt = tail;
                  tail_nxt = din;
               end
               default: begin
                  head_nxt = din;
                  occ_nxt  = OCC_ONE;
               end
            endcase
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/fifo_rd_drain.sv
// Read-side drain engine: credit-limited FIFO strobes into a 2-entry stream buffer.
// Optional FIFO_RD_DRAIN_COUNT_EN adds a 32-bit accepted-word counter port.
module fifo_rd_drain
   import fifo_rd_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic            rd_clk,
   input  logic            rd_rstn,
   input  logic            drain_en,
   fifo_rd_drain_if.master bus,
   output logic            idle
`ifdef FIFO_RD_DRAIN_COUNT_EN
   ,
   output logic [31:0]     rd_count
`endif
);

   occ_t                  occ;
   logic [DATA_WIDTH-1:0] head;
   logic                  inflight;
   logic                  pop;

   assign pop         = bus.m_valid & bus.m_ready;
   assign bus.m_valid = (occ != OCC_EMPTY);
   assign bus.m_data  = head;

   // Strobe only when the word it returns is guaranteed a free slot.
   assign bus.fifo_rd_en = rd_rstn & drain_en & ~bus.fifo_empty &
                           (credit_sum(occ, inflight, pop) < 3'(RD_BUF_DEPTH));

   always_ff @(posedge rd_clk) begin
      if (!rd_rstn) inflight <= 1'b0;
      else          inflight <= bus.fifo_rd_en;
   end

   rd_skid_buf #(
      .DATA_WIDTH(DATA_WIDTH)
   ) u_buf (
      .clk (rd_clk),
      .rstn(rd_rstn),
      .push(inflight),
      .pop (pop),
      .din (bus.fifo_rdata),
      .occ (occ),
      .head(head)
   );

   assign idle = (occ == OCC_EMPTY) & ~inflight;

`ifdef FIFO_RD_DRAIN_COUNT_EN
   logic [31:0] rd_cnt;

   always_ff @(posedge rd_clk) begin
      if (!rd_rstn)  rd_cnt <= '0;
      else if (pop)  rd_cnt <= rd_cnt + 32'd1;
   end

   assign rd_count = rd_cnt;
`endif

endmodule
